note_stream_receiver: RTL and testbench

NOTE_STREAM_RECEIVER -- requirements
Module: note_stream_receiver

---
 rtl/rhythm_pkg.sv | 21 ++
 rtl/note_fifo.sv | 100 ++++++++++
 rtl/note_stream_receiver.sv | 138 +++++++++++++
 tb/tb_note_stream_receiver.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rhythm_pkg.sv
// Shared constants and types for the note stream receiver.
//   DEPTH      : note queue entries (power of two)
//   HIT_LO/HI  : inclusive window of map-tick ages that count as a hit
//   NOTE_BASE  : first note position emitted by the generators
//   NOTE_STEP  : position increment between successive generator notes
//   AGE_W      : width of the per-note age counter (saturates at all-ones)
package rhythm_pkg;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned HIT_LO    = 6;
  localparam int unsigned HIT_HI    = 9;
  localparam int unsigned NOTE_BASE = 200;
  localparam int unsigned NOTE_STEP = 4;
  localparam int unsigned AGE_W     = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/note_fifo.sv
// Circular note queue with a per-entry age counter.
//   clk, resetn : system clock, asynchronous active-low reset
//   push        : enqueue push_pos at age 0 (dropped when full unless a pop
//                 happens on the same edge)
//   push_pos    : note position to enqueue
//   pop         : discard the head entry (ignored when empty)
//   age_en      : increment the age of every entry held before this edge
//   head_pos    : head note position, 0 when empty
//   head_age    : head note age
//   count       : entries held, 0..DEPTH
//   full, empty : occupancy flags
module note_fifo
  import rhythm_pkg::AGE_W;
#(
  parameter int unsigned DEPTH = rhythm_pkg::DEPTH
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic [7:0]             push_pos,
  input  logic                   pop,
  input  logic                   age_en,
  output logic [7:0]             head_pos,
  output logic [AGE_W-1:0]       head_age,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]       pos_q [DEPTH];
  logic [7:0]       pos_d [DEPTH];
  logic [AGE_W-1:0] age_q [DEPTH];
  logic [AGE_W-1:0] age_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] slot_off;
  logic             pop_ok;
  logic             push_ok;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign head_pos = empty ? '0 : pos_q[rd_ptr_q];
  assign head_age = age_q[rd_ptr_q];

  always_comb begin
    pos_d    = pos_q;
    age_d    = age_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    slot_off = '0;
    pop_ok   = pop & ~empty;
    // A pop on the same edge frees the slot the push is about to reuse.
    push_ok  = push & (~full | pop_ok);

    // Only slots inside the occupied window age; stale slots are left alone.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot_off = PTR_W'(i) - rd_ptr_q;
      if (age_en && ({1'b0, slot_off} < count_q) && (age_q[i] != '1)) begin
        age_d[i] = age_q[i] + 1'b1;
      end
    end

    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Written after aging so a freshly pushed note always starts at 0.
    if (push_ok) begin
      pos_d[wr_ptr_q] = push_pos;
      age_d[wr_ptr_q] = '0;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end

    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pos_q[i] <= '0;
        age_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pos_q    <= pos_d;
      age_q    <= age_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/note_stream_receiver.sv
// Rhythm-game note judge: queues notes from the generator stream, ages them
// on every scroll tick and judges player key presses as hits or misses.
//   clk, resetn : system clock, asynchronous active-low reset
//   map         : scroll tick strobe
//   data_en     : generator note valid (sampled with map)
//   data        : generator note position
//   key         : player button level (synchronous, active-high)
//   hit, miss   : one-cycle judgement pulses for the head note
//   score       : saturating hit counter
//   misses      : saturating miss counter
//   count       : notes queued, 0..DEPTH
//   head_pos    : head note position, 0 when the queue is empty
//   overflow    : sticky, set when a push was dropped on a full queue
module note_stream_receiver
  import rhythm_pkg::state_e;
  import rhythm_pkg::ST_IDLE;
  import rhythm_pkg::ST_RUN;
  import rhythm_pkg::AGE_W;
#(
  parameter int unsigned DEPTH  = rhythm_pkg::DEPTH,
  parameter int unsigned HIT_LO = rhythm_pkg::HIT_LO,
  parameter int unsigned HIT_HI = rhythm_pkg::HIT_HI
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   map,
  input  logic                   data_en,
  input  logic [7:0]             data,
  input  logic                   key,
  output logic                   hit,
  output logic                   miss,
  output logic [7:0]             score,
  output logic [7:0]             misses,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             head_pos,
  output logic                   overflow
);

  localparam logic [AGE_W-1:0] HIT_LO_A = AGE_W'(HIT_LO);
  localparam logic [AGE_W-1:0] HIT_HI_A = AGE_W'(HIT_HI);

  state_e     state_q, state_d;
  logic       key_q, key_d;
  logic       hit_q, hit_d;
  logic       miss_q, miss_d;
  logic [7:0] score_q, score_d;
  logic [7:0] misses_q, misses_d;
  logic       overflow_q, overflow_d;

  logic             key_rise;
  logic             push;
  logic             run;
  logic             in_window;
  logic             hit_ev;
  logic             miss_ev;
  logic             pop;
  logic             age_en;
  logic [AGE_W-1:0] head_age;
  logic             fifo_full;
  logic             fifo_empty;

  note_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (push),
    .push_pos (data),
    .pop      (pop),
    .age_en   (age_en),
    .head_pos (head_pos),
    .head_age (head_age),
    .count    (count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    key_d      = key;
    score_d    = score_q;
    misses_d   = misses_q;

    key_rise   = key & ~key_q;
    // A note arriving in IDLE is both the start trigger and the first push.
    push       = map & data_en;
    run        = (state_q == ST_RUN);
    in_window  = ~fifo_empty & (head_age >= HIT_LO_A) & (head_age <= HIT_HI_A);
    hit_ev     = run & key_rise & in_window;
    // A hit on the same edge already consumes the head, so the miss yields.
    miss_ev    = run & map & ~fifo_empty & (head_age == HIT_HI_A) & ~hit_ev;
    pop        = hit_ev | miss_ev;
    age_en     = run & map;

    unique case (state_q)
      ST_IDLE: if (push) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase

    hit_d  = hit_ev;
    miss_d = miss_ev;
    if (hit_ev && (score_q != '1)) begin
      score_d = score_q + 1'b1;
    end
    if (miss_ev && (misses_q != '1)) begin
      misses_d = misses_q + 1'b1;
    end
    overflow_d = overflow_q | (push & fifo_full & ~pop);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      key_q      <= 1'b0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      score_q    <= '0;
      misses_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      score_q    <= score_d;
      misses_q   <= misses_d;
      overflow_q <= overflow_d;
    end
  end

  assign hit      = hit_q;
  assign miss     = miss_q;
  assign score    = score_q;
  assign misses   = misses_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_note_stream_receiver.sv
module tb_note_stream_receiver;

  localparam int M_DEPTH = 4;
  localparam int M_LO    = 6;
  localparam int M_HI    = 9;
  localparam int BASE    = 200;
  localparam int STEP    = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic       map;
  logic       data_en;
  logic [7:0] data;
  logic       key;
  logic       hit;
  logic       miss;
  logic [7:0] score;
  logic [7:0] misses;
  logic [2:0] count;
  logic [7:0] head_pos;
  logic       overflow;

  note_stream_receiver #(
    .DEPTH  (M_DEPTH),
    .HIT_LO (M_LO),
    .HIT_HI (M_HI)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .map      (map),
    .data_en  (data_en),
    .data     (data),
    .key      (key),
    .hit      (hit),
    .miss     (miss),
    .score    (score),
    .misses   (misses),
    .count    (count),
    .head_pos (head_pos),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: notes as (position, age) queues, judged from the rules directly.
  int qpos[$];
  int qage[$];
  bit m_run, m_keyq, m_hit, m_miss, m_ovf;
  int m_score, m_misses;

  function automatic int m_head();
    return (qpos.size() > 0) ? qpos[0] : 0;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      qpos.delete();
      qage.delete();
      m_run = 0; m_keyq = 0; m_hit = 0; m_miss = 0; m_ovf = 0;
      m_score = 0; m_misses = 0;
    end else begin
      bit kr, psh, h, ms;
      kr  = key && !m_keyq;
      m_keyq = key;
      psh = map && data_en;
      h   = m_run && kr && qpos.size() > 0 && qage[0] >= M_LO && qage[0] <= M_HI;
      ms  = m_run && map && qpos.size() > 0 && !h && qage[0] == M_HI;
      if (h || ms) begin
        void'(qpos.pop_front());
        void'(qage.pop_front());
      end
      if (m_run && map)
        foreach (qage[i]) qage[i] = (qage[i] >= 15) ? 15 : qage[i] + 1;
      if (psh) begin
        if (qpos.size() < M_DEPTH) begin
          qpos.push_back(int'(data));
          qage.push_back(0);
        end else begin
          m_ovf = 1;
        end
      end
      m_hit  = h;
      m_miss = ms;
      if (h && m_score < 255) m_score++;
      if (ms && m_misses < 255) m_misses++;
      if (psh) m_run = 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Pins both the DUT and the model to a hand-computed value.
  task automatic lit(input string name, input logic [31:0] dut_v, input logic [31:0] mdl_v,
                     input logic [31:0] exp);
    chk({name, "_dut"}, dut_v, exp);
    chk({name, "_model"}, mdl_v, exp);
  endtask

  always @(negedge clk) begin
    chk("hit",      {31'd0, hit},      {31'd0, m_hit});
    chk("miss",     {31'd0, miss},     {31'd0, m_miss});
    chk("score",    {24'd0, score},    m_score);
    chk("misses",   {24'd0, misses},   m_misses);
    chk("count",    {29'd0, count},    qpos.size());
    chk("head_pos", {24'd0, head_pos}, m_head());
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
  end

  task automatic cyc(input bit m, input bit de, input int d, input bit k);
    map     = m;
    data_en = de;
    data    = d[7:0];
    key     = k;
    @(negedge clk);
  endtask

  task automatic all_zero(input string tag);
    lit({tag, "_count"},    count,    qpos.size(), 0);
    lit({tag, "_score"},    score,    m_score,     0);
    lit({tag, "_misses"},   misses,   m_misses,    0);
    lit({tag, "_hit"},      hit,      m_hit,       0);
    lit({tag, "_miss"},     miss,     m_miss,      0);
    lit({tag, "_overflow"}, overflow, m_ovf,       0);
    lit({tag, "_head_pos"}, head_pos, m_head(),    0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hits_dut, hits_mdl;
    resetn = 1'b1; map = 0; data_en = 0; data = '0; key = 0;
    #1 resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    all_zero("reset");
    resetn = 1'b1;

    // Hit at age 7
    cyc(1, 1, BASE, 0);
    lit("s1_count", count, qpos.size(), 1);
    lit("s1_head", head_pos, m_head(), 200);
    repeat (7) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    lit("s1_hit", hit, m_hit, 1);
    lit("s1_score", score, m_score, 1);
    lit("s1_count_after", count, qpos.size(), 0);
    cyc(0, 0, 0, 0);
    lit("s1_hit_drop", hit, m_hit, 0);

    // Miss on the tick after age 9
    cyc(1, 1, BASE + STEP, 0);
    repeat (9) cyc(1, 0, 0, 0);
    lit("s2_count_pre", count, qpos.size(), 1);
    lit("s2_misses_pre", misses, m_misses, 0);
    cyc(1, 0, 0, 0);
    lit("s2_miss", miss, m_miss, 1);
    lit("s2_misses", misses, m_misses, 1);
    lit("s2_count", count, qpos.size(), 0);
    cyc(0, 0, 0, 0);
    lit("s2_miss_drop", miss, m_miss, 0);

    // Early press ignored, held key judged once
    cyc(1, 1, BASE + 2 * STEP, 0);
    repeat (3) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    lit("s3_early_hit", hit, m_hit, 0);
    lit("s3_early_count", count, qpos.size(), 1);
    cyc(0, 0, 0, 0);
    repeat (4) cyc(1, 0, 0, 0);
    hits_dut = 0;
    hits_mdl = 0;
    repeat (20) begin
      cyc(0, 0, 0, 1);
      hits_dut += int'(hit);
      hits_mdl += int'(m_hit);
    end
    lit("s3_held_hits", hits_dut, hits_mdl, 1);
    lit("s3_score", score, m_score, 2);
    lit("s3_count", count, qpos.size(), 0);
    cyc(0, 0, 0, 0);

    // Five pushes into a four-entry queue
    for (int i = 0; i < 5; i++) cyc(1, 1, BASE + STEP * i, 0);
    lit("s4_count", count, qpos.size(), 4);
    lit("s4_overflow", overflow, m_ovf, 1);
    lit("s4_head", head_pos, m_head(), 200);

    // Head at age 9 with key and map on the same edge
    repeat (5) cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    lit("s5_hit", hit, m_hit, 1);
    lit("s5_miss", miss, m_miss, 0);
    lit("s5_count", count, qpos.size(), 3);
    lit("s5_score", score, m_score, 3);

    // Mid-cycle reset with three notes queued
    map = 0; data_en = 0; key = 0;
    #2 resetn = 1'b0;
    #1 all_zero("midreset");
    @(negedge clk);
    resetn = 1'b1;

    // IDLE ignores map and key without data_en
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    lit("idle_count", count, qpos.size(), 0);
    lit("idle_score", score, m_score, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 1, BASE, 0);
    lit("post_reset_count", count, qpos.size(), 1);
    lit("post_reset_head", head_pos, m_head(), 200);

    // Full queue: miss pop and push on one edge keep count at DEPTH
    for (int i = 1; i < 4; i++) cyc(1, 1, BASE + STEP * i, 0);
    repeat (6) cyc(1, 0, 0, 0);
    cyc(1, 1, 240, 0);
    lit("s7_miss", miss, m_miss, 1);
    lit("s7_count", count, qpos.size(), 4);
    lit("s7_overflow", overflow, m_ovf, 0);
    lit("s7_head", head_pos, m_head(), 204);
    cyc(0, 0, 0, 1);
    lit("s7_hit", hit, m_hit, 1);
    lit("s7_head_after", head_pos, m_head(), 208);
    cyc(0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
